unpool_layer: RTL and testbench
===============================

# unpool_layer

Inverse of the 2x2 average-pool stage in the CNN core: expands a 3x3 pooled feature map back to 6x6 by replicating each pooled value over its 2x2 window. In gradient mode it instead distributes value/4 to each window position, which is the backward pass of average pooling. Output is written into a 6x6 array and also streamed one pixel per handshake in raster order, so a downstream conv or line-buffer stage can consume it with backpressure.

## Interface
- `IN_W`, default 3: pooled map width; output width is 2*IN_W.
- `IN_H`, default 3: pooled map height; output height is 2*IN_H.
- `clk`  input  1  clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  begin a frame; sampled only in IDLE.
- `grad_mode`  input  1  0 = replicate, 1 = arithmetic shift right by 2; sampled with `start`.
- `input_fm`  input  signed 32 x [0:IN_W*IN_H-1]  pooled map, row-major; must be valid on the `start` cycle and the following cycle.
- `out_valid`  output  1  `out_data`/`out_index` hold a pixel.
- `out_ready`  input  1  downstream accepts the pixel when high with `out_valid`.
- `out_data`  output  signed 32  current pixel value.
- `out_index`  output  6  raster index of current pixel, `row*2*IN_W + col`.
- `output_fm`  output  signed 32 x [0:4*IN_W*IN_H-1]  expanded map; entry written on acceptance.
- `busy`  output  1  frame in progress.
- `done`  output  1  one-cycle pulse after last pixel accepted.

## Operation
- FSM states:
  - IDLE: `start` goes to LATCH; `grad_mode` is captured.
  - LATCH: copies `input_fm` into an internal 9-entry buffer; row=col=0; goes to EMIT.
  - EMIT: presents the pixel at (row,col); on `out_valid && out_ready`, writes `output_fm[out_index]` and advances col, wrapping to 0 and incrementing row at col=2*IN_W-1. Acceptance of (2*IN_H-1, 2*IN_W-1) goes to FIN.
  - FIN: `done`=1 for one cycle, then IDLE.
- Source buffer index is `(row>>1)*IN_W + (col>>1)`.
- Value is `src` when `grad_mode`=0, or `src >>> 2` when `grad_mode`=1. The shift is sign-preserving and rounds toward minus infinity (-7 -> -2); there is no saturation.
- `out_valid` = (state==EMIT). `busy` = (state in LATCH, EMIT, FIN).
- Later changes to `input_fm` and `grad_mode` do not affect a frame in flight.
- `start` while busy is ignored. `start` held high in IDLE after FIN begins a new frame.
- `output_fm` entries not yet rewritten in a new frame keep their previous values.

## Timing
- Reset (asynchronous, any state): state=IDLE, row=col=0, all `output_fm` entries are 0. `out_valid`, `out_data`, `out_index`, `busy` and `done` are all 0. An in-flight frame is abandoned with no `done`.
- `start` sampled at edge N:
  - LATCH after N;
  - `out_valid` high after N+1, presenting pixel 0.
- With `out_ready` held at 1:
  - one pixel is accepted per edge, N+2 through N+37;
  - `done` is high for the cycle after N+37;
  - IDLE after N+38.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_index` and internal counters hold; `output_fm` is not written. Each stall cycle adds one cycle of latency.
- `output_fm[k]` updates at the same edge that accepts pixel k.
- `done` and `out_valid` are never high in the same cycle.

## Test plan
- **Reset:** assert `rst` asynchronously mid-EMIT, with no clock edge. Required: all outputs 0 and `output_fm` zeroed immediately; no `done` follows.
- **Replicate:** `input_fm` = 1..9, `grad_mode`=0, `out_ready`=1. Required:
  - `output_fm[0,1,6,7]`=1, `[4,5,10,11]`=3, `[28,29,34,35]`=9;
  - `out_index` runs 0..35 consecutively;
  - `done` at N+38.
- **Gradient:** `input_fm[0]`=-7, `[4]`=100, `[8]`=2^31-1, `grad_mode`=1. Required: `output_fm[0]`=-2, `output_fm[14]`=25, `output_fm[35]`=536870911.
- **Backpressure:** `out_ready` toggles 1,0,0,1 repeatedly. Required:
  - `out_data` and `out_index` are stable during stalls;
  - exactly 36 acceptances with no duplicates or skips;
  - `done` is delayed accordingly.
- **Input isolation:** change `input_fm` and `grad_mode` at N+2, and pulse `start` mid-frame. Required: output matches values sampled at N/N+1; `start` is ignored; one `done`.
- **Back-to-back:** `start` held high across FIN. Required: second frame starts in the cycle after `done`; `busy` low for exactly one cycle, in IDLE.

Source files
------------

// File: rtl/unpool_if.sv
// Pixel stream from unpool_layer to a downstream consumer.
// The producer drives valid/data/index, and the consumer drives ready.
interface unpool_if;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic [5:0]         out_index;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    output out_ready
  );
endinterface

// File: rtl/unpool_layer.sv
// 2x2 un-pooling: expands an IN_W x IN_H map to 2*IN_W x 2*IN_H.
// Each source value is either replicated or divided by four (avg-pool backward pass).
// The result is streamed in raster order with backpressure and is also stored in output_fm.
module unpool_layer #(
  parameter int IN_W = 3,
  parameter int IN_H = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               grad_mode,
  input  logic signed [31:0] input_fm  [0:IN_W*IN_H-1],
  output logic signed [31:0] output_fm [0:4*IN_W*IN_H-1],
  output logic               busy,
  output logic               done,
  unpool_if.master           bus
);
  localparam int SRC_N  = IN_W * IN_H;
  localparam int OUT_W  = 2 * IN_W;
  localparam int OUT_H  = 2 * IN_H;
  localparam int OUT_N  = 4 * SRC_N;
  localparam int COL_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_AW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int SRC_AW = (SRC_N > 1) ? $clog2(SRC_N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_EMIT,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_AW-1:0]   row_q, row_d;
  logic [COL_AW-1:0]   col_q, col_d;
  logic                grad_q, grad_d;
  logic                latch_en;
  logic                accept;

  logic signed [31:0]  src_q [0:SRC_N-1];
  logic signed [31:0]  src_d [0:SRC_N-1];
  logic signed [31:0]  ofm_q [0:OUT_N-1];
  logic signed [31:0]  ofm_d [0:OUT_N-1];

  logic [SRC_AW-1:0]   src_idx;
  logic [5:0]          pix_idx;
  logic signed [31:0]  src_val;
  logic signed [31:0]  pix_val;

  // Each output pixel maps back to the pooled cell that covers its 2x2 window.
  assign src_idx = SRC_AW'(row_q >> 1) * SRC_AW'(IN_W) + SRC_AW'(col_q >> 1);
  assign pix_idx = 6'(row_q) * 6'(OUT_W) + 6'(col_q);
  assign src_val = src_q[src_idx];
  assign pix_val = grad_q ? (src_val >>> 2) : src_val;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    grad_d   = grad_q;
    latch_en = 1'b0;
    accept   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LATCH;
          grad_d  = grad_mode;
        end
      end
      S_LATCH: begin
        latch_en = 1'b1;
        row_d    = '0;
        col_d    = '0;
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          accept = 1'b1;
          if (col_q == COL_AW'(OUT_W - 1)) begin
            col_d = '0;
            if (row_q == ROW_AW'(OUT_H - 1)) begin
              row_d   = '0;
              state_d = S_FIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The frame uses a private copy of the source map, so later input changes are not seen.
  always_comb begin
    for (int i = 0; i < SRC_N; i++) begin
      src_d[i] = latch_en ? input_fm[i] : src_q[i];
    end
  end

  always_comb begin
    for (int k = 0; k < OUT_N; k++) begin
      ofm_d[k] = (accept && (pix_idx == 6'(k))) ? pix_val : ofm_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      grad_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      grad_q  <= grad_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SRC_N; i++) begin
        src_q[i] <= '0;
      end
      for (int k = 0; k < OUT_N; k++) begin
        ofm_q[k] <= '0;
      end
    end else begin
      for (int i = 0; i < SRC_N; i++) begin
        src_q[i] <= src_d[i];
      end
      for (int k = 0; k < OUT_N; k++) begin
        ofm_q[k] <= ofm_d[k];
      end
    end
  end

  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_data  = bus.out_valid ? pix_val : '0;
  assign bus.out_index = bus.out_valid ? pix_idx : '0;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FIN);
  assign output_fm     = ofm_q;

endmodule

// File: tb/tb_unpool_layer.sv
// Randomised bench for unpool_layer.
// It compares the DUT against a window-replication / floor-divide-by-4 model.
module tb_unpool_layer;
  localparam int IN_W  = 3;
  localparam int IN_H  = 3;
  localparam int SRC_N = IN_W * IN_H;
  localparam int OUT_W = 2 * IN_W;
  localparam int OUT_N = 4 * SRC_N;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               grad_mode;
  logic signed [31:0] input_fm  [0:SRC_N-1];
  logic signed [31:0] output_fm [0:OUT_N-1];
  logic               busy;
  logic               done;

  logic signed [31:0] cur_in [0:SRC_N-1];
  logic signed [31:0] exp_px [0:OUT_N-1];
  int                 n_checks = 0;
  int                 n_errors = 0;

  unpool_if u_if ();

  unpool_layer #(.IN_W(IN_W), .IN_H(IN_H)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .grad_mode (grad_mode),
    .input_fm  (input_fm),
    .output_fm (output_fm),
    .busy      (busy),
    .done      (done),
    .bus       (u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(got ^ got ^ exp));
    end
  endtask

  // Each output pixel takes its window's pooled value.
  // In gradient mode, that value is floor-divided by 4.
  function automatic void build_expected(input bit grad);
    for (int r = 0; r < 2 * IN_H; r++) begin
      for (int c = 0; c < OUT_W; c++) begin
        longint v;
        v = cur_in[(r / 2) * IN_W + c / 2];
        if (grad) v = (v >= 0) ? v / 4 : -((-v + 3) / 4);
        exp_px[r * OUT_W + c] = 32'(v);
      end
    end
  endfunction

  function automatic logic ready_at(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return (i % 4 == 0) || (i % 4 == 3);
      default: return ($urandom_range(0, 9) < 7);
    endcase
  endfunction

  task automatic randomize_input();
    for (int i = 0; i < SRC_N; i++) cur_in[i] = $urandom;
  endtask

  // On entry with skip_start set, the DUT is already in LATCH.
  // On exit, the DUT is in the IDLE cycle that follows FIN.
  task automatic run_frame(input bit grad, input int mode, input bit hold,
                           input bit skip_start, input bit disturb);
    int                 cyc;
    int                 acc;
    int                 stalls;
    bit                 done_seen;
    bit                 prev_stall;
    bit                 pend;
    logic signed [31:0] prev_data;
    logic [5:0]         prev_idx;
    logic [5:0]         pend_idx;
    build_expected(grad);
    if (!skip_start) begin
      for (int i = 0; i < SRC_N; i++) input_fm[i] = cur_in[i];
      grad_mode = grad;
      start     = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
    end
    check("latch_busy", busy, 1);
    check("latch_valid", u_if.out_valid, 0);
    @(posedge clk); #1;
    if (disturb) begin
      for (int i = 0; i < SRC_N; i++) input_fm[i] = $urandom;
      grad_mode = !grad;
    end
    cyc = 0; acc = 0; stalls = 0; done_seen = 0; prev_stall = 0; pend = 0;
    prev_data = '0; prev_idx = '0; pend_idx = '0;
    while (!done_seen && cyc < 400) begin
      if (disturb && cyc == 5) start = 1'b1;
      if (disturb && cyc == 6) start = 1'b0;
      u_if.out_ready = ready_at(mode, cyc);
      if (pend) begin
        check("ofm_update", output_fm[pend_idx], exp_px[pend_idx]);
        pend = 0;
      end
      check("done_valid_excl", done && u_if.out_valid, 0);
      if (done) begin
        done_seen = 1;
        check("done_time", cyc, 36 + stalls);
        check("accept_count", acc, OUT_N);
      end else if (u_if.out_valid) begin
        if (prev_stall) begin
          check("stall_data", u_if.out_data, prev_data);
          check("stall_index", u_if.out_index, prev_idx);
        end
        if (u_if.out_ready) begin
          if (acc < OUT_N) begin
            check("px_index", u_if.out_index, acc);
            check("px_data", u_if.out_data, exp_px[acc]);
          end else begin
            check("extra_pixel", acc, OUT_N - 1);
          end
          pend     = 1;
          pend_idx = u_if.out_index;
          acc++;
          prev_stall = 0;
        end else begin
          stalls++;
          prev_stall = 1;
          prev_data  = u_if.out_data;
          prev_idx   = u_if.out_index;
        end
      end
      if (!done_seen) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!done_seen) check("done_timeout", 0, 1);
    for (int k = 0; k < OUT_N; k++) check("frame_ofm", output_fm[k], exp_px[k]);
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("done_pulse", done, 0);
    $display("frame grad=%0d mode=%0d hold=%0d disturb=%0d accepted=%0d stalls=%0d",
             grad, mode, hold, disturb, acc, stalls);
  endtask

  initial begin
    int nz;
    int done_cnt;
    int busy_cnt;
    bit g;
    rst = 1'b1; start = 1'b0; grad_mode = 1'b0; u_if.out_ready = 1'b0;
    for (int i = 0; i < SRC_N; i++) input_fm[i] = '0;
    #12;
    check("rst_valid", u_if.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_index", u_if.out_index, 0);
    check("rst_data", u_if.out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy0", busy, 0);

    // Replicate mode with source values 1..9.
    for (int i = 0; i < SRC_N; i++) cur_in[i] = i + 1;
    run_frame(1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("rep_ofm0", output_fm[0], 1);
    check("rep_ofm7", output_fm[7], 1);
    check("rep_ofm4", output_fm[4], 3);
    check("rep_ofm11", output_fm[11], 3);
    check("rep_ofm28", output_fm[28], 9);
    check("rep_ofm35", output_fm[35], 9);

    // Gradient mode with negative, mid-range and maximum source values.
    randomize_input();
    cur_in[0] = -7; cur_in[4] = 100; cur_in[8] = 32'sh7fffffff;
    run_frame(1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("grad_ofm0", output_fm[0], -2);
    check("grad_ofm14", output_fm[14], 25);
    check("grad_ofm35", output_fm[35], 536870911);

    // Backpressure with a 1,0,0,1 ready pattern.
    randomize_input();
    run_frame(1'(($urandom) & 1), 1, 1'b0, 1'b0, 1'b0);

    // Input changes after latch, plus a start pulse during the frame.
    randomize_input();
    run_frame(1'b0, 2, 1'b0, 1'b0, 1'b1);
    randomize_input();
    run_frame(1'b1, 2, 1'b0, 1'b0, 1'b1);

    // Back-to-back frames with start held high.
    randomize_input();
    g = 1'(($urandom) & 1);
    run_frame(g, 0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_frame(g, 0, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_stop", busy, 0);

    for (int n = 0; n < 4; n++) begin
      randomize_input();
      run_frame(1'(($urandom) & 1), 2, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of EMIT.
    randomize_input();
    for (int i = 0; i < SRC_N; i++) input_fm[i] = cur_in[i] | 32'sd1;
    u_if.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    check("pre_rst_valid", u_if.out_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_valid", u_if.out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_index", u_if.out_index, 0);
    check("arst_data", u_if.out_data, 0);
    nz = 0;
    for (int k = 0; k < OUT_N; k++) if (output_fm[k] != 0) nz++;
    check("arst_ofm_nonzero", nz, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("post_rst_done", done_cnt, 0);
    check("post_rst_busy", busy_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
